bus_rr_arbiter: RTL and testbench



---
 rtl/bus_rr_arbiter_pkg.sv | 25 ++
 rtl/bus_rr_arbiter_rr_pick.sv | 39 +++
 rtl/bus_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_arbiter_pkg
// Brief    : Shared bus constants, active-low enable levels and arbiter
//            state encodings used by the system bus round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bus_rr_arbiter_pkg;

    // Bus master channel count and owner ID width of the system bus
    localparam int BUS_MASTER_CH = 4;
    localparam int BUS_OWNER_W   = 2;

    // Active-low control levels shared with the rest of the bus
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Arbiter states: nobody owns the bus / exactly one master owns it
    typedef enum logic [0:0] {
        ARB_ST_IDLE  = 1'b0,
        ARB_ST_GRANT = 1'b1
    } arb_state_t;

endpackage : bus_rr_arbiter_pkg
`default_nettype wire

// File: rtl/bus_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_arbiter_rr_pick
// Brief    : Combinational round-robin picker. Returns the first requesting
//            master scanning last+1, last+2, ... modulo NUM_M.
// Revision : 1.0 - initial release
// ============================================================================
module bus_rr_arbiter_rr_pick
    import bus_rr_arbiter_pkg::*;
#(
    parameter int NUM_M = BUS_MASTER_CH,
    parameter int ID_W  = BUS_OWNER_W
) (
    input  logic [NUM_M-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    // Rotation distance from last; the requester with the smallest distance wins
    always_comb begin
        int w_dist;
        int w_best;
        winner = '0;
        valid  = 1'b0;
        w_dist = 0;
        w_best = NUM_M;
        for (int j = 0; j < NUM_M; j++) begin
            w_dist = (j - int'(last) - 1 + 2 * NUM_M) % NUM_M;
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                winner = ID_W'(j);
                valid  = 1'b1;
            end
        end
    end

endmodule : bus_rr_arbiter_rr_pick
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_arbiter
// Brief    : Round-robin system bus arbiter with active-low request/grant
//            lines, registered owner ID and busy flag. Grants park on the
//            owner; a release hands over directly to the next requester.
//            Optional feature macro ARB_TIMEOUT_EN adds a forced revoke of a
//            grant held TIMEOUT_CYC cycles while others wait and the bus
//            strobe is idle.
// Revision : 1.0 - initial release
// ============================================================================
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int NUM_M       = BUS_MASTER_CH,
    parameter int ID_W        = BUS_OWNER_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_M-1:0] req_,
    input  logic             bus_as_,
    output logic [NUM_M-1:0] grnt_,
    output logic [ID_W-1:0]  owner,
    output logic             busy,
    output logic             timeout_evt
);

    localparam logic [NUM_M-1:0] C_ONE = {{(NUM_M-1){1'b0}}, 1'b1};

    arb_state_t       r_state;
    logic [NUM_M-1:0] r_grnt;
    logic [ID_W-1:0]  r_owner;
    logic [ID_W-1:0]  r_last;
    logic             r_busy;

    logic [NUM_M-1:0] w_req;
    logic [NUM_M-1:0] w_owner_oh;
    logic [NUM_M-1:0] w_pick_req;
    logic [NUM_M-1:0] w_pick_oh;
    logic [ID_W-1:0]  w_pick;
    logic             w_pick_valid;
    logic             w_owner_req;
    logic             w_revoke;

    assign w_req       = ~req_;
    assign w_owner_oh  = C_ONE << r_owner;
    assign w_owner_req = |(w_req & w_owner_oh);
    // While granted, the owner is excluded so the picker only sees competitors
    assign w_pick_req  = (r_state == ARB_ST_GRANT) ? (w_req & ~w_owner_oh) : w_req;
    assign w_pick_oh   = C_ONE << w_pick;

    bus_rr_arbiter_rr_pick #(
        .NUM_M (NUM_M),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req    (w_pick_req),
        .last   (r_last),
        .winner (w_pick),
        .valid  (w_pick_valid)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int              CNT_W     = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_evt;

    // Revoke only once the hold limit is reached, someone else waits and no strobe is active
    assign w_revoke    = (r_cnt == C_CNT_MAX) && bus_as_ && w_pick_valid;
    assign timeout_evt = r_timeout_evt;
`else
    logic w_unused;

    assign w_revoke    = 1'b0;
    assign timeout_evt = 1'b0;
    assign w_unused    = bus_as_ & (TIMEOUT_CYC > 0);
`endif

    // Arbiter state machine with registered grant, owner and busy outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ARB_ST_IDLE;
            r_grnt  <= {NUM_M{DISABLE_}};
            r_owner <= '0;
            r_busy  <= 1'b0;
            r_last  <= ID_W'(NUM_M - 1);
`ifdef ARB_TIMEOUT_EN
            r_cnt         <= '0;
            r_timeout_evt <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_timeout_evt <= 1'b0;
`endif
            case (r_state)
                ARB_ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= ARB_ST_GRANT;
                        r_grnt  <= ~w_pick_oh;
                        r_owner <= w_pick;
                        r_last  <= w_pick;
                        r_busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                ARB_ST_GRANT: begin
                    if (w_owner_req && !w_revoke) begin
                        // Bus parks on the owner while it keeps requesting
`ifdef ARB_TIMEOUT_EN
                        if (r_cnt != C_CNT_MAX) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
`endif
                    end else if (w_pick_valid) begin
                        // Direct handover: old grant drops and new one asserts on one edge
                        r_grnt  <= ~w_pick_oh;
                        r_owner <= w_pick;
                        r_last  <= w_pick;
`ifdef ARB_TIMEOUT_EN
                        r_cnt         <= '0;
                        r_timeout_evt <= w_revoke;
`endif
                    end else begin
                        r_state <= ARB_ST_IDLE;
                        r_grnt  <= {NUM_M{DISABLE_}};
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ARB_ST_IDLE;
                    r_grnt  <= {NUM_M{DISABLE_}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grnt_ = r_grnt;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule : bus_rr_arbiter
`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_rr_arbiter
// Brief    : Self-checking bench for bus_rr_arbiter: directed scenarios plus
//            random request traffic, compared against a scoreboard of
//            expected grant/owner/busy/timeout values.
//            Timeout scenarios are built only with ARB_TIMEOUT_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_rr_arbiter;

    localparam int NM = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TC = 8;
`else
    localparam int TC = 64;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] req_    = 4'hF;
    logic       bus_as_ = 1'b1;
    logic [3:0] grnt_;
    logic [1:0] owner;
    logic       busy;
    logic       timeout_evt;

    always #5 clk = ~clk;

    bus_rr_arbiter #(
        .NUM_M       (NM),
        .ID_W        (2),
        .TIMEOUT_CYC (TC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_        (req_),
        .bus_as_     (bus_as_),
        .grnt_       (grnt_),
        .owner       (owner),
        .busy        (busy),
        .timeout_evt (timeout_evt)
    );

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] o;
        logic       b;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    int m_busy  = 0;
    int m_owner = 0;
    int m_last  = NM - 1;
    int m_cnt   = 0;
    bit m_evt   = 1'b0;

    function automatic int pick(input logic [3:0] rq, input int last);
        for (int k = 1; k <= NM; k++) begin
            int idx;
            idx = (last + k) % NM;
            if (rq[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_busy  = 1;
        m_owner = w;
        m_last  = w;
        m_cnt   = 0;
    endtask

    // Advance the model with the inputs just driven and queue the expected outputs
    task automatic model_push();
        logic [3:0] rq;
        logic [3:0] om;
        exp_t       e;
        int         w;
        rq    = ~req_;
        om    = 4'b0001 << m_owner;
        m_evt = 1'b0;
        if (!reset) begin
            m_busy  = 0;
            m_owner = 0;
            m_last  = NM - 1;
            m_cnt   = 0;
        end else if (m_busy == 0) begin
            w = pick(rq, m_last);
            if (w >= 0) model_grant(w);
        end else if ((rq & om) != 4'b0000) begin
`ifdef ARB_TIMEOUT_EN
            if (m_cnt == TC && bus_as_ && ((rq & ~om) != 4'b0000)) begin
                w = pick(rq & ~om, m_last);
                model_grant(w);
                m_evt = 1'b1;
            end else if (m_cnt < TC) begin
                m_cnt++;
            end
`endif
        end else begin
            w = pick(rq, m_last);
            if (w >= 0) model_grant(w);
            else m_busy = 0;
        end
        e.g = (m_busy != 0) ? ~(4'b0001 << m_owner) : 4'hF;
        e.o = m_owner[1:0];
        e.b = (m_busy != 0);
        e.e = m_evt;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty: observed=0 entries expected=1");
        end else begin
            e = sb.pop_front();
            checks++;
            assert (grnt_ === e.g) else begin
                failures++;
                $error("FAIL grnt_: observed=%b expected=%b", grnt_, e.g);
            end
            checks++;
            assert (busy === e.b) else begin
                failures++;
                $error("FAIL busy: observed=%b expected=%b", busy, e.b);
            end
            if (e.b) begin
                checks++;
                assert (owner === e.o) else begin
                    failures++;
                    $error("FAIL owner: observed=%0d expected=%0d", owner, e.o);
                end
            end
            checks++;
            assert (timeout_evt === e.e) else begin
                failures++;
                $error("FAIL timeout_evt: observed=%b expected=%b", timeout_evt, e.e);
            end
            checks++;
            assert ($onehot0(~grnt_)) else begin
                failures++;
                $error("FAIL onehot: observed grnt_=%b expected at most one low bit", grnt_);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic as_n);
        @(negedge clk);
        req_    = r;
        bus_as_ = as_n;
        model_push();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    int pend [NM];
    int rem  [NM];
    int waitp[NM];
    bit jrel [NM];

    initial begin
        int         held;
        int         prev_busy;
        int         prev_owner;
        logic [3:0] r;

        // Reset state
        reset = 1'b0;
        step(4'hF, 1'b1);
        step(4'hF, 1'b1);
        chk("rst_grnt", {4'h0, grnt_}, 8'h0F);
        chk("rst_owner", {6'h0, owner}, 8'h00);
        chk("rst_busy", {7'h0, busy}, 8'h00);
        chk("rst_evt", {7'h0, timeout_evt}, 8'h00);
        reset = 1'b1;

        // Single request: 1-cycle latency, release returns to idle
        step(4'b1101, 1'b1);
        chk("m1_grant", {4'h0, grnt_}, 8'h0D);
        chk("m1_owner", {6'h0, owner}, 8'h01);
        for (int i = 0; i < 7; i++) step(4'b1101, 1'b1);
        step(4'b1111, 1'b1);
        chk("m1_release", {4'h0, grnt_}, 8'h0F);
        chk("m1_rel_busy", {7'h0, busy}, 8'h00);

        // All four from reset, each releasing after 3 cycles of ownership
        reset = 1'b0;
        step(4'hF, 1'b1);
        reset = 1'b1;
        step(4'b0000, 1'b1);
        chk("all_m0", {4'h0, grnt_}, 8'h0E);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b1);
        chk("all_m1", {4'h0, grnt_}, 8'h0D);
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0011, 1'b1);
        chk("all_m2", {4'h0, grnt_}, 8'h0B);
        step(4'b0011, 1'b1);
        step(4'b0011, 1'b1);
        step(4'b0111, 1'b1);
        chk("all_m3", {4'h0, grnt_}, 8'h07);
        step(4'b0111, 1'b1);
        step(4'b0111, 1'b1);
        step(4'b1111, 1'b1);
        chk("all_idle", {4'h0, grnt_}, 8'h0F);

        // Parking: m0 holds for 200 cycles while m1 waits
        step(4'b1110, 1'b1);
        held = 0;
        for (int i = 0; i < 200; i++) begin
            step(4'b1100, 1'b1);
            if (grnt_ == 4'b1110) held++;
        end
`ifdef ARB_TIMEOUT_EN
        // With revoke enabled the hold is cut short; the model covers exact timing
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
`else
        chk("park_held", held[7:0], 8'd200);
        step(4'b1101, 1'b1);
        chk("park_m1", {4'h0, grnt_}, 8'h0D);
        step(4'b1111, 1'b1);
`endif

        // Reset while m2 owns the bus, then m0 beats m2
        step(4'b1011, 1'b1);
        chk("rst_m2_grant", {4'h0, grnt_}, 8'h0B);
        step(4'b1011, 1'b1);
        reset = 1'b0;
        step(4'b1011, 1'b1);
        chk("midrst_grnt", {4'h0, grnt_}, 8'h0F);
        chk("midrst_owner", {6'h0, owner}, 8'h00);
        reset = 1'b1;
        step(4'b1010, 1'b1);
        chk("postrst_m0", {4'h0, grnt_}, 8'h0E);
        step(4'b1111, 1'b1);

`ifdef ARB_TIMEOUT_EN
        // Forced revoke with bus_as_ high
        step(4'b1110, 1'b1);
        held = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0110, 1'b1);
            if (grnt_ == 4'b0111) break;
            held++;
        end
        chk("to_held", held[7:0], 8'(TC));
        chk("to_grnt", {4'h0, grnt_}, 8'h07);
        chk("to_evt", {7'h0, timeout_evt}, 8'h01);
        step(4'b1110, 1'b1);
        chk("to_back_m0", {4'h0, grnt_}, 8'h0E);
        // Revoke deferred while the strobe stays low
        held = 0;
        for (int i = 0; i < 15; i++) begin
            step(4'b0110, 1'b0);
            if (grnt_ == 4'b1110) held++;
        end
        chk("to_defer", held[7:0], 8'd15);
        step(4'b0110, 1'b1);
        chk("to_late_grnt", {4'h0, grnt_}, 8'h07);
        chk("to_late_evt", {7'h0, timeout_evt}, 8'h01);
        step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
`endif

        // Random traffic with a well-behaved request protocol
        for (int i = 0; i < NM; i++) begin
            pend[i]  = 0;
            rem[i]   = 0;
            waitp[i] = 0;
            jrel[i]  = 1'b0;
        end
        prev_busy  = 0;
        prev_owner = 0;
        for (int c = 0; c < 10000; c++) begin
            r = 4'hF;
            for (int i = 0; i < NM; i++) begin
                if (pend[i] == 0 && !jrel[i] && $urandom_range(0, 3) == 0) pend[i] = 1;
                jrel[i] = 1'b0;
                if (pend[i] != 0) r[i] = 1'b0;
            end
            step(r, ($urandom_range(0, 3) != 0));
            if (busy && (prev_busy == 0 || int'(owner) != prev_owner)) begin
                for (int i = 0; i < NM; i++) begin
                    if (i == int'(owner)) begin
                        checks++;
                        assert (waitp[i] <= NM - 1) else begin
                            failures++;
                            $error("FAIL starve m%0d: observed=%0d periods expected<=%0d", i, waitp[i], NM - 1);
                        end
                        waitp[i] = 0;
                        rem[i]   = $urandom_range(1, 4);
                    end else if (pend[i] != 0) begin
                        waitp[i]++;
                    end
                end
            end
            if (busy) begin
                rem[owner]--;
                if (rem[owner] <= 0) begin
                    pend[owner] = 0;
                    jrel[owner] = 1'b1;
                end
            end
            prev_busy  = busy ? 1 : 0;
            prev_owner = int'(owner);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bus_rr_arbiter
`default_nettype wire
